// File: rtl/mem_sram_pkg.sv
// Shared constants and state encoding for the MEM-stage SRAM responder.
// Covers both the default build and the SRAM_LAST_READ_BUF_EN build.
package mem_sram_pkg;

    localparam int          DEF_WAIT_CYCLES = 4;
    localparam logic [31:0] DEF_BASE_ADDR   = 32'd1024;
    localparam int          DEF_SRAM_AW     = 18;
    localparam int          SRAM_DW         = 16;
    localparam int          CNT_W           = 4;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE  = 3'd0;
    localparam state_t ST_WR_LO = 3'd1;
    localparam state_t ST_WR_HI = 3'd2;
    localparam state_t ST_RD_LO = 3'd3;
    localparam state_t ST_RD_HI = 3'd4;
    localparam state_t ST_DONE  = 3'd5;

    function automatic logic is_phase(input state_t s);
        return (s == ST_WR_LO) || (s == ST_WR_HI) || (s == ST_RD_LO) || (s == ST_RD_HI);
    endfunction

endpackage

// File: rtl/mem_sram_addr_map.sv
// Byte address to SRAM halfword address translation (low half at 2w, high half at 2w+1).
// Purely combinational; the word index wraps silently at the SRAM size.
module mem_sram_addr_map
    import mem_sram_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = DEF_BASE_ADDR,
    parameter int          SRAM_AW   = DEF_SRAM_AW
) (
    input  logic [31:0]        address,
    output logic [SRAM_AW-1:0] hw_lo,
    output logic [SRAM_AW-1:0] hw_hi,
    output logic [SRAM_AW-2:0] word_idx
);

    localparam logic [SRAM_AW-2:0] BASE_WORD = BASE_ADDR[SRAM_AW:2];

    logic unused_addr_bits;

    // Only the bits that survive truncation take part in the subtraction.
    assign word_idx = address[SRAM_AW:2] - BASE_WORD;
    assign hw_lo    = {word_idx, 1'b0};
    assign hw_hi    = {word_idx, 1'b1};

    assign unused_addr_bits = ^{address[31:SRAM_AW+1], address[1:0]};

endmodule

// File: rtl/mem_sram_ctrl.sv
// MEM-stage responder splitting 32-bit loads/stores into two 16-bit async SRAM phases.
// Optional one-entry last-read buffer enabled by defining SRAM_LAST_READ_BUF_EN.
//
// state | meaning
// IDLE  | waiting for wr_en / rd_en
// WR_LO | driving low halfword, we_n low
// WR_HI | driving high halfword, we_n low
// RD_LO | reading low halfword, sampled on last cycle
// RD_HI | reading high halfword, sampled on last cycle
// DONE  | one release cycle, bus turned around
module mem_sram_ctrl
    import mem_sram_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = DEF_BASE_ADDR,
    parameter int          SRAM_AW     = DEF_SRAM_AW,
    parameter int          WAIT_CYCLES = DEF_WAIT_CYCLES
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               wr_en,
    input  logic               rd_en,
    input  logic [31:0]        address,
    input  logic [31:0]        write_data,
    output logic [31:0]        read_data,
    output logic               ready,
    output logic [SRAM_AW-1:0] sram_addr,
    output logic [15:0]        sram_dq_out,
    output logic               sram_dq_oe,
    input  logic [15:0]        sram_dq_in,
    output logic               sram_we_n
);

    localparam logic [CNT_W-1:0] PHASE_LAST = CNT_W'(WAIT_CYCLES - 1);

    state_t             state;
    state_t             next_state;
    logic [CNT_W-1:0]   counter;
    logic [15:0]        lo_hold;
    logic [SRAM_AW-1:0] hw_lo;
    logic [SRAM_AW-1:0] hw_hi;
    logic [SRAM_AW-2:0] word_idx;
    logic               phase_end;
    logic               buf_hit;

    mem_sram_addr_map #(
        .BASE_ADDR (BASE_ADDR),
        .SRAM_AW   (SRAM_AW)
    ) u_addr_map (
        .address  (address),
        .hw_lo    (hw_lo),
        .hw_hi    (hw_hi),
        .word_idx (word_idx)
    );

    assign phase_end = is_phase(state) && (counter == '0);

`ifdef SRAM_LAST_READ_BUF_EN
    logic               buf_valid;
    logic [SRAM_AW-2:0] buf_idx;
    logic [31:0]        buf_data;

    assign buf_hit = buf_valid && (buf_idx == word_idx);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            buf_valid <= 1'b0;
            buf_idx   <= '0;
            buf_data  <= '0;
        end else if (state == ST_RD_HI && phase_end) begin
            buf_valid <= 1'b1;
            buf_idx   <= word_idx;
            buf_data  <= {sram_dq_in, lo_hold};
        end else if (state == ST_WR_HI && phase_end && buf_hit) begin
            buf_data  <= write_data;
        end
    end
`else
    logic unused_word_idx;

    assign buf_hit         = 1'b0;
    assign unused_word_idx = ^word_idx;
`endif

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: begin
                if (wr_en)
                    next_state = ST_WR_LO;
                else if (rd_en)
                    next_state = buf_hit ? ST_DONE : ST_RD_LO;
            end
            ST_WR_LO: if (phase_end) next_state = ST_WR_HI;
            ST_WR_HI: if (phase_end) next_state = ST_DONE;
            ST_RD_LO: if (phase_end) next_state = ST_RD_HI;
            ST_RD_HI: if (phase_end) next_state = ST_DONE;
            ST_DONE:  next_state = ST_IDLE;
            default:  next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= ST_IDLE;
        else
            state <= next_state;
    end

    // Down-counter reloaded on every phase entry; the phase ends when it reaches zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            counter <= '0;
        else if (next_state != state && is_phase(next_state))
            counter <= PHASE_LAST;
        else if (counter != '0)
            counter <= counter - 1'b1;
    end

    // Bus outputs are registered from next_state so they line up with the state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sram_addr   <= '0;
            sram_dq_out <= '0;
            sram_dq_oe  <= 1'b0;
            sram_we_n   <= 1'b1;
        end else begin
            case (next_state)
                ST_WR_LO: begin
                    sram_addr   <= hw_lo;
                    sram_dq_out <= write_data[15:0];
                    sram_dq_oe  <= 1'b1;
                    sram_we_n   <= 1'b0;
                end
                ST_WR_HI: begin
                    sram_addr   <= hw_hi;
                    sram_dq_out <= write_data[31:16];
                    sram_dq_oe  <= 1'b1;
                    sram_we_n   <= 1'b0;
                end
                ST_RD_LO: begin
                    sram_addr   <= hw_lo;
                    sram_dq_oe  <= 1'b0;
                    sram_we_n   <= 1'b1;
                end
                ST_RD_HI: begin
                    sram_addr   <= hw_hi;
                    sram_dq_oe  <= 1'b0;
                    sram_we_n   <= 1'b1;
                end
                default: begin
                    sram_dq_oe  <= 1'b0;
                    sram_we_n   <= 1'b1;
                end
            endcase
        end
    end

    // Low half is staged so read_data only changes once a full read completes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lo_hold   <= '0;
            read_data <= '0;
        end else if (state == ST_RD_LO && phase_end) begin
            lo_hold   <= sram_dq_in;
        end else if (state == ST_RD_HI && phase_end) begin
            read_data <= {sram_dq_in, lo_hold};
`ifdef SRAM_LAST_READ_BUF_EN
        end else if (state == ST_IDLE && next_state == ST_DONE) begin
            read_data <= buf_data;
`endif
        end
    end

    assign ready = rst
                 || (state == ST_IDLE && !wr_en && !rd_en)
                 || (state == ST_DONE);

endmodule

// File: tb/tb_mem_sram_ctrl.sv
// Self-checking bench for mem_sram_ctrl: default instance plus a WAIT_CYCLES=1 instance,
// each attached to a behavioural async SRAM; expectations come from a word-level model.
module tb_mem_sram_ctrl;

    localparam int WA = 4;
    localparam int WB = 1;
`ifdef SRAM_LAST_READ_BUF_EN
    localparam bit BUF_EN = 1'b1;
`else
    localparam bit BUF_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        wr_a, rd_a, rdy_a, oe_a, we_n_a;
    logic [31:0] addr_a, wd_a, rdata_a;
    logic [17:0] saddr_a;
    logic [15:0] dqo_a, dqi_a;

    logic        wr_b, rd_b, rdy_b, oe_b, we_n_b;
    logic [31:0] addr_b, wd_b, rdata_b;
    logic [17:0] saddr_b;
    logic [15:0] dqo_b, dqi_b;

    logic [15:0] mem_a [0:262143];
    logic [15:0] mem_b [0:262143];

    assign dqi_a = mem_a[saddr_a];
    assign dqi_b = mem_b[saddr_b];

    always @(posedge clk) begin
        if (!we_n_a && oe_a) mem_a[saddr_a] <= dqo_a;
        if (!we_n_b && oe_b) mem_b[saddr_b] <= dqo_b;
    end

    mem_sram_ctrl dut_a (
        .clk(clk), .rst(rst), .wr_en(wr_a), .rd_en(rd_a), .address(addr_a),
        .write_data(wd_a), .read_data(rdata_a), .ready(rdy_a), .sram_addr(saddr_a),
        .sram_dq_out(dqo_a), .sram_dq_oe(oe_a), .sram_dq_in(dqi_a), .sram_we_n(we_n_a)
    );

    mem_sram_ctrl #(.WAIT_CYCLES(WB)) dut_b (
        .clk(clk), .rst(rst), .wr_en(wr_b), .rd_en(rd_b), .address(addr_b),
        .write_data(wd_b), .read_data(rdata_b), .ready(rdy_b), .sram_addr(saddr_b),
        .sram_dq_out(dqo_b), .sram_dq_oe(oe_b), .sram_dq_in(dqi_b), .sram_we_n(we_n_b)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    // Word-level reference: contents by word index, last visible read_data, last-read buffer.
    logic [31:0] ref_word [int];
    logic [31:0] exp_rdata = '0;
    bit          mb_valid  = 1'b0;
    int          mb_w      = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int sel, input logic w, input logic r,
                         input logic [31:0] a, input logic [31:0] d);
        if (sel == 0) begin
            wr_a = w; rd_a = r; addr_a = a; wd_a = d;
        end else begin
            wr_b = w; rd_b = r; addr_b = a; wd_b = d;
        end
    endtask

    // One access from an idle controller; returns what was seen on the bus.
    task automatic op(input int sel, input logic w, input logic r,
                      input logic [31:0] a, input logic [31:0] d,
                      output int busy, output int we_low,
                      output logic [17:0] first_addr, output logic [17:0] last_addr,
                      output logic [31:0] rdata, output logic pre_stall,
                      output logic done_quiet, output logic tmo);
        logic        c_rdy, c_we_n, c_oe;
        logic [17:0] c_addr;
        busy = 0; we_low = 0; first_addr = '0; last_addr = '0;
        rdata = '0; done_quiet = 1'b0; tmo = 1'b1;
        drive(sel, w, r, a, d);
        @(negedge clk);
        pre_stall = (sel == 0) ? !rdy_a : !rdy_b;
        for (int i = 0; i < 64 && tmo; i++) begin
            @(negedge clk);
            c_rdy  = (sel == 0) ? rdy_a   : rdy_b;
            c_we_n = (sel == 0) ? we_n_a  : we_n_b;
            c_oe   = (sel == 0) ? oe_a    : oe_b;
            c_addr = (sel == 0) ? saddr_a : saddr_b;
            if (c_rdy) begin
                tmo        = 1'b0;
                rdata      = (sel == 0) ? rdata_a : rdata_b;
                done_quiet = c_we_n && !c_oe;
            end else begin
                if (busy == 0) first_addr = c_addr;
                last_addr = c_addr;
                busy++;
                if (!c_we_n) we_low++;
            end
        end
        @(posedge clk);
        #1;
        drive(sel, 1'b0, 1'b0, a, d);
    endtask

    task automatic write_and_check(input string tag, input logic [31:0] a,
                                   input logic [31:0] d, input logic rd_too);
        int busy, we_low, w;
        logic [17:0] fa, la;
        logic [31:0] rd;
        logic ps, dq, tmo;
        w = (int'(a) - 1024) >>> 2;
        op(0, 1'b1, rd_too, a, d, busy, we_low, fa, la, rd, ps, dq, tmo);
        chk({tag, "_tmo"},    32'(tmo), 32'd0);
        chk({tag, "_stall0"}, 32'(ps), 32'd1);
        chk({tag, "_busy"},   busy, 2 * WA);
        chk({tag, "_we_low"}, we_low, 2 * WA);
        chk({tag, "_addr_lo"}, fa, 32'(2 * w));
        chk({tag, "_addr_hi"}, la, 32'(2 * w + 1));
        chk({tag, "_done_bus"}, 32'(dq), 32'd1);
        chk({tag, "_rdata_kept"}, rd, exp_rdata);
        chk({tag, "_mem_lo"}, mem_a[2 * w], d[15:0]);
        chk({tag, "_mem_hi"}, mem_a[2 * w + 1], d[31:16]);
        ref_word[w] = d;
    endtask

    task automatic read_and_check(input string tag, input logic [31:0] a);
        int busy, we_low, w, eb;
        logic [17:0] fa, la;
        logic [31:0] rd, exp;
        logic ps, dq, tmo;
        w   = (int'(a) - 1024) >>> 2;
        exp = ref_word.exists(w) ? ref_word[w] : 32'd0;
        eb  = (BUF_EN && mb_valid && mb_w == w) ? 0 : 2 * WA;
        op(0, 1'b0, 1'b1, a, 32'd0, busy, we_low, fa, la, rd, ps, dq, tmo);
        chk({tag, "_tmo"},    32'(tmo), 32'd0);
        chk({tag, "_stall0"}, 32'(ps), 32'd1);
        chk({tag, "_busy"},   busy, eb);
        chk({tag, "_we_low"}, we_low, 32'd0);
        chk({tag, "_data"},   rd, exp);
        chk({tag, "_done_bus"}, 32'(dq), 32'd1);
        if (eb != 0) begin
            chk({tag, "_addr_lo"}, fa, 32'(2 * w));
            chk({tag, "_addr_hi"}, la, 32'(2 * w + 1));
        end
        mb_valid  = 1'b1;
        mb_w      = w;
        exp_rdata = exp;
    endtask

    initial begin
        int          wq[$];
        int          wi, k_sel;
        logic [31:0] d;
        int          busy, we_low;
        logic [17:0] fa, la;
        logic [31:0] rd;
        logic        ps, dq, tmo;

        drive(0, 1'b0, 1'b0, 32'd0, 32'd0);
        drive(1, 1'b0, 1'b0, 32'd0, 32'd0);
        repeat (2) @(negedge clk);
        chk("rst_ready", 32'(rdy_a), 32'd1);
        chk("rst_we_n",  32'(we_n_a), 32'd1);
        chk("rst_oe",    32'(oe_a), 32'd0);
        chk("rst_rdata", rdata_a, 32'd0);
        chk("rst_addr",  saddr_a, 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        write_and_check("wr1024", 32'd1024, 32'hDEADBEEF, 1'b0);
        read_and_check("rd1024", 32'd1024);
        write_and_check("wr1036", 32'd1036, 32'hA5C3_0F96, 1'b0);
        read_and_check("rd1036", 32'd1036);
        write_and_check("wrrd1028", 32'd1028, 32'h12345678, 1'b1);

        for (int k = 0; k < 4; k++) begin
            wi = $urandom_range(8, 31);
            d  = $urandom;
            write_and_check("rnd_wr", 32'(1024 + 4 * wi), d, 1'b0);
            wq.push_back(wi);
        end
        for (int k = 0; k < 6; k++) begin
            k_sel = $urandom_range(0, wq.size() - 1);
            read_and_check("rnd_rd", 32'(1024 + 4 * wq[k_sel]));
        end

        // Abort a write on the third cycle of its high phase.
        drive(0, 1'b1, 1'b0, 32'd1024, 32'hDEADBEEF);
        @(negedge clk);
        repeat (WA + 3) @(negedge clk);
        chk("abort_pre_we_n", 32'(we_n_a), 32'd0);
        rst = 1'b1;
        #1;
        chk("abort_we_n",  32'(we_n_a), 32'd1);
        chk("abort_oe",    32'(oe_a), 32'd0);
        chk("abort_ready", 32'(rdy_a), 32'd1);
        chk("abort_rdata", rdata_a, 32'd0);
        @(negedge clk);
        drive(0, 1'b0, 1'b0, 32'd0, 32'd0);
        rst = 1'b0;
        mb_valid  = 1'b0;
        exp_rdata = '0;
        #1;
        chk("abort_idle_ready", 32'(rdy_a), 32'd1);
        @(posedge clk);
        #1;
        read_and_check("rd_after_abort", 32'd1024);

        // Last-read buffer sequence; without the buffer every read takes full latency.
        read_and_check("buf_rd1036", 32'd1036);
        read_and_check("buf_rd1024a", 32'd1024);
        read_and_check("buf_rd1024b", 32'd1024);
        write_and_check("buf_wr_cafe", 32'd1024, 32'h0000CAFE, 1'b0);
        read_and_check("buf_rd_cafe", 32'd1024);

        // Single-cycle phases on the second instance, including back-to-back reads.
        op(1, 1'b1, 1'b0, 32'd1024, 32'hDEADBEEF, busy, we_low, fa, la, rd, ps, dq, tmo);
        chk("b_wr_tmo", 32'(tmo), 32'd0);
        chk("b_wr_busy", busy, 2 * WB);
        chk("b_wr_we_low", we_low, 2 * WB);
        chk("b_wr_mem", {mem_b[1], mem_b[0]}, 32'hDEADBEEF);
        d = $urandom;
        op(1, 1'b1, 1'b0, 32'd1032, d, busy, we_low, fa, la, rd, ps, dq, tmo);
        chk("b_wr2_busy", busy, 2 * WB);
        op(1, 1'b0, 1'b1, 32'd1024, 32'd0, busy, we_low, fa, la, rd, ps, dq, tmo);
        chk("b_rd1_tmo", 32'(tmo), 32'd0);
        chk("b_rd1_busy", busy, 2 * WB);
        chk("b_rd1_data", rd, 32'hDEADBEEF);
        op(1, 1'b0, 1'b1, 32'd1032, 32'd0, busy, we_low, fa, la, rd, ps, dq, tmo);
        chk("b_rd2_tmo", 32'(tmo), 32'd0);
        chk("b_rd2_busy", busy, 2 * WB);
        chk("b_rd2_addr_lo", fa, 32'd4);
        chk("b_rd2_addr_hi", la, 32'd5);
        chk("b_rd2_data", rd, d);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mem_sram_ctrl.md
Name: mem_sram_ctrl

Overview:
- Memory-stage responder between the MEM stage and an external 16-bit asynchronous SRAM. It replaces the single-cycle data memory that feeds the MEM/WB register.
- Accepts one 32-bit load or store per request. Splits it into two 16-bit SRAM phases (low half first) and returns read_data.
- Holds ready low while busy so hazard/freeze logic stalls every pipeline register.

Parameters:
- BASE_ADDR, 1024: byte address mapped to SRAM halfword 0.
- SRAM_AW, 18: SRAM halfword address width.
- WAIT_CYCLES, 4: clock cycles per SRAM phase; legal range 1..15.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- wr_en  in  1  store request (MEM stage)
- rd_en  in  1  load request (MEM stage)
- address  in  32  byte address; must be word-aligned
- write_data  in  32  store data
- read_data  out  32  load data; valid while ready=1 after a read completes
- ready  out  1  0 = freeze pipeline
- sram_addr  out  SRAM_AW  halfword address
- sram_dq_out  out  16  write data to SRAM
- sram_dq_oe  out  1  1 = controller drives DQ
- sram_dq_in  in  16  read data from SRAM
- sram_we_n  out  1  active-low write strobe

Behaviour:
- Reset: rst is asynchronous and active-high; clk is the clock. All state is asynchronously reset.
  - Reset values: state=IDLE, counter=0, read_data=0, sram_addr=0, sram_dq_out=0, sram_dq_oe=0, sram_we_n=1.
  - ready is 1 during reset.
  - Reset mid-operation aborts immediately. we_n goes high and oe low asynchronously, and no partial data is retained.
- Address map: w = (address - BASE_ADDR) >> 2. The low half goes to halfword 2w, the high half to 2w+1. The result is truncated to SRAM_AW bits; wrap-around is silent. address[1:0] is ignored.
- FSM states: IDLE, WR_LO, WR_HI, RD_LO, RD_HI, DONE.
  - IDLE: wr_en=1 → WR_LO. Otherwise rd_en=1 → RD_LO. Writes take priority when both are asserted.
  - WR_LO / WR_HI: sram_addr = 2w / 2w+1. dq_out = write_data[15:0] / [31:16]. oe=1 and we_n=0 for all WAIT_CYCLES cycles of the phase.
  - RD_LO / RD_HI: oe=0 and we_n=1. sram_dq_in is sampled on the last cycle of the phase into read_data[15:0] / [31:16].
  - Phase transitions: each phase lasts exactly WAIT_CYCLES cycles, tracked by a 4-bit counter. LO → HI, then HI → DONE.
  - DONE: lasts 1 cycle with ready=1, then returns to IDLE. Inputs are ignored in DONE.
  - During DONE, sram_we_n=1 and oe=0 (the bus turns around).
- ready = (state==IDLE && !wr_en && !rd_en) || state==DONE. ready is combinational from state and the request inputs.
- Latency: a request seen at edge 0 gives ready=0 for 2*WAIT_CYCLES cycles, then ready=1 in DONE. With the default, that is 8 stall cycles followed by 1 release cycle.
- Back-to-back accesses: request inputs are held by the frozen pipeline. After DONE → IDLE, a new memory instruction's request starts the next access on the following edge.
- Persistence: read_data holds its last value until the next completed read. Writes never alter read_data (except with the optional feature).

Optional Feature:
- Macro: SRAM_LAST_READ_BUF_EN.
- Enabled: one-entry buffer {valid, word index, data}.
  - IDLE with rd_en=1 and buffer hit: no SRAM access. read_data is loaded from the buffer, ready is 0 for that cycle, and the FSM goes IDLE → DONE (2-cycle total).
  - A completed read fills the buffer.
  - A write to the same word updates the buffer data.
  - Reset clears valid.
- Disabled: no buffer; every read takes the full latency.

Decomposition:
- Shared package (mem_sram_pkg): state encoding enum, default WAIT_CYCLES, BASE_ADDR, and the SRAM width constants.
- Sub-module mem_sram_addr_map: combinational byte-address → halfword-address translation.
- The FSM, counter and datapath stay in mem_sram_ctrl.

Test Plan:
- Write 0xDEADBEEF to 1024: sram_addr 0 gets 0xBEEF and 1 gets 0xDEAD. we_n is low for 4 cycles per phase, ready is 0 for 8 cycles, then 1 for 1 cycle.
- Read 1024 with the SRAM model holding those values: read_data=0xDEADBEEF in DONE. Read 1036: sram_addr 6 then 7.
- wr_en and rd_en both set at 1028 with write_data 0x12345678: write performed (halfwords 2 and 3), read_data unchanged.
- Reset asserted on the 3rd cycle of WR_HI: we_n=1 and oe=0 immediately, ready=1, state IDLE. After release, a read of 1024 restarts cleanly.
- WAIT_CYCLES=1: a write takes 2 stall cycles. Two back-to-back reads (1024, 1032) each show ready=0 for 2 cycles, separated by one DONE cycle.
- SRAM_LAST_READ_BUF_EN: read 1024 (8 stalls), read 1024 again (1 stall, no SRAM activity), write 0x0000CAFE to 1024, then read 1024 → 0x0000CAFE without SRAM access.
